// File: rtl/fsm_reg_file_demo.sv
// Fibonacci fill of a 16x16 register file via an internal adder; one write per cycle, state 15 terminal.
// Outputs are combinational from current state (zero latency); no backpressure, self-running.
module fsm_reg_file_demo (
    input  logic        clk,
    input  logic        reset,
    output logic [27:0] display,
    output logic [15:0] rout,
    output logic [3:0]  state
);

    localparam logic [3:0] S_INIT = 4'd0;
    localparam logic [3:0] S_LAST = 4'd15;

    logic [15:0] regs_q [16];
    logic [3:0]  state_q, state_d;

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_dat;
    logic [15:0] rd_a_dat, rd_b_dat, sum_dat;

    // Port A is addressed by state and doubles as the rout port.
    assign rd_a_dat = regs_q[state_q];
    assign rd_b_dat = regs_q[state_q - 4'd1];
    assign sum_dat  = rd_a_dat + rd_b_dat;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = state_q + 4'd1;
        wr_dat  = sum_dat;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_dat  = 16'h0001;
                state_d = state_q + 4'd1;
            end
            S_LAST: begin
                state_d = S_LAST;
            end
            default: begin
                wr_en   = 1'b1;
                state_d = state_q + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_dat;
        end
    end

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign rout    = rd_a_dat;
    assign state   = state_q;
    assign display = {hex_to_seg(rd_a_dat[15:12]), hex_to_seg(rd_a_dat[11:8]),
                      hex_to_seg(rd_a_dat[7:4]),   hex_to_seg(rd_a_dat[3:0])};

endmodule

// File: tb/tb_fsm_reg_file_demo.sv
// Randomized bench for fsm_reg_file_demo against a Fibonacci/segment-table reference model.
module tb_fsm_reg_file_demo;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset  = 1'b0;
    logic [27:0] display;
    logic [15:0] rout;
    logic [3:0]  state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ms       = 0;
    logic [15:0] fib     [16];
    logic [6:0]  seg_tab [16];

    fsm_reg_file_demo dut (
        .clk     (clk),
        .reset   (reset),
        .display (display),
        .rout    (rout),
        .state   (state)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [27:0] exp_disp(input logic [15:0] v);
        return {seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset && ms < 15) ms++;
    endtask

    task automatic restart();
        @(negedge clk);
        reset = 1'b0;
        ms    = 0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++;
        if (rout !== 16'h0000) begin n_fail++; $display("FAIL reset_rout got %h want 0000", rout); end
        n_checks++;
        if (display !== 28'h8102040) begin n_fail++; $display("FAIL reset_display got %h want 8102040", display); end
        clk_en = 1'b1;
    endtask

    task automatic test_sequence();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++;
            if (state !== 4'(k)) begin n_fail++; $display("FAIL seq_state k=%0d got %0d want %0d", k, state, k); end
            n_checks++;
            if (rout !== fib[k]) begin n_fail++; $display("FAIL seq_rout k=%0d got %0d want %0d", k, rout, fib[k]); end
            n_checks++;
            if (display !== exp_disp(fib[k])) begin n_fail++; $display("FAIL seq_display k=%0d got %h want %h", k, display, exp_disp(fib[k])); end
        end
        n_checks++;
        if (rout !== 16'd610) begin n_fail++; $display("FAIL final_rout got %0d want 610", rout); end
        n_checks++;
        if (display !== {7'b1000000, 7'b0100100, 7'b0000010, 7'b0100100}) begin
            n_fail++; $display("FAIL final_display got %h want digits 2,6,2,0", display);
        end
    endtask

    task automatic test_hold();
        int n;
        n = 10 + int'($urandom_range(0, 5));
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if (state !== 4'd15 || rout !== 16'd610) begin
                n_fail++; $display("FAIL hold i=%0d got state=%0d rout=%0d want 15/610", i, state, rout);
            end
        end
    endtask

    task automatic test_async_reset(input int tgt);
        restart();
        repeat (tgt) tick();
        n_checks++;
        if (rout !== fib[tgt]) begin n_fail++; $display("FAIL pre_reset_rout tgt=%0d got %0d want %0d", tgt, rout, fib[tgt]); end
        #($urandom_range(1, 3));
        reset = 1'b0;
        ms    = 0;
        #1;
        n_checks++;
        if (state !== 4'd0 || rout !== 16'h0000 || display !== 28'h8102040) begin
            n_fail++; $display("FAIL async_reset tgt=%0d got state=%0d rout=%0d disp=%h want 0/0/8102040", tgt, state, rout, display);
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0 || rout !== 16'h0000) begin
            n_fail++; $display("FAIL reset_held got state=%0d rout=%0d want 0/0", state, rout);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (state !== 4'd3 || rout !== 16'd2) begin
            n_fail++; $display("FAIL post_reset got state=%0d rout=%0d want 3/2", state, rout);
        end
    endtask

    task automatic test_state12();
        restart();
        repeat (12) tick();
        n_checks++;
        if (rout !== 16'h0090) begin n_fail++; $display("FAIL s12_rout got %h want 0090", rout); end
        n_checks++;
        if (display !== {7'b1000000, 7'b1000000, 7'b0010000, 7'b1000000}) begin
            n_fail++; $display("FAIL s12_display got %h want digits 0,9,0,0", display);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            restart();
            n = int'($urandom_range(0, 25));
            repeat (n) tick();
            n_checks++;
            if (state !== 4'(ms) || rout !== fib[ms] || display !== exp_disp(fib[ms])) begin
                n_fail++;
                $display("FAIL random it=%0d n=%0d got state=%0d rout=%0d disp=%h want %0d/%0d/%h",
                         it, n, state, rout, display, ms, fib[ms], exp_disp(fib[ms]));
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        fib[0] = 16'd0;
        fib[1] = 16'd1;
        for (int i = 2; i < 16; i++) fib[i] = 16'(int'(fib[i-1]) + int'(fib[i-2]));

        test_reset();
        test_sequence();
        test_hold();
        test_async_reset(7);
        test_async_reset(int'($urandom_range(1, 14)));
        test_state12();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_reg_file_demo.md
Name: fsm_reg_file_demo

Overview:
Self-running demo controller that fills an internal 16x16-bit register file with the Fibonacci sequence using an internal adder. It exposes the current state, the selected register value, and a 4-digit hex seven-segment rendering of that value. It is the board-level smoke test for the register file and ALU datapath. There are no data inputs; the only inputs are clock and reset.

Parameters:
None (data width fixed at 16, register count fixed at 16, state width fixed at 4).

Ports:
clk      input   1   system clock; all state changes on the rising edge
reset    input   1   asynchronous, active-low reset
display  output  28  four seven-segment digits, active-low segments
rout     output  16  contents of register r[state]
state    output  4   current FSM state / step index

Behaviour:
- Clocking and reset:
  - One clock domain, `clk`, rising edge.
  - `reset` is asynchronous and active-low; while `reset` = 0, hold everything in reset.
  - On reset assertion: `state` = 0 and all 16 registers r0..r15 = 16'h0000, immediately and without waiting for a clock edge.
- Internal blocks:
  - 16x16 register file with two combinational read ports and one synchronous write port (write enable, 4-bit write address).
  - 16-bit adder; results wrap modulo 2^16 and carry is discarded.
- State transitions and writes, on each rising edge with `reset` = 1:
  - state 0: write r1 <= 16'h0001; next state 1.
  - state s, 1 <= s <= 14: write r[s+1] <= r[s] + r[s-1] (adder output); next state s+1.
  - state 15: terminal. No register writes; state holds at 15 until reset.
- Exactly one register write per cycle in states 0-14, and none in state 15.
- rout:
  - Combinational r[state]; a third read port, or read port A addressed by `state`, is acceptable.
  - During state s, `rout` = F(s), the Fibonacci sequence with F(0)=0, F(1)=1.
  - Full sequence: 0,1,1,2,3,5,8,13,21,34,55,89,144,233,377,610.
  - After reset: `rout` = 0.
- state: the registered FSM state itself.
- display:
  - Combinational hex decode of `rout`.
  - Digit layout: display[6:0] = rout[3:0], display[13:7] = rout[7:4], display[20:14] = rout[11:8], display[27:21] = rout[15:12].
  - Within each digit: bit0 = a, bit1 = b, ... bit6 = g. Segments are active-low (0 = lit).
  - Patterns g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-sequence (any state): asynchronously return to state 0 with all registers cleared. The sequence restarts from F(0) on the first edge after `reset` deasserts.
- No X on any output after reset.

Test Plan:
- Assert `reset` = 0 with no clock edges -> `state` = 0, `rout` = 0, `display` = 28'h8102040 (four "0" digits).
- Release reset, apply 15 rising edges -> after edge k, `state` = k and `rout` = F(k); after edge 15, `state` = 15 and `rout` = 16'd610 (16'h0262).
- At state 15 -> `display` digits low-to-high = 0100100 ("2"), 0000010 ("6"), 0100100 ("2"), 1000000 ("0").
- Apply 10 further edges at state 15 -> `state` stays 15, `rout` stays 610, no register changes.
- Assert `reset` low asynchronously at state 7 (`rout` = 13), between clock edges -> `state` = 0 and `rout` = 0 immediately; release reset, 3 edges -> `state` = 3, `rout` = 2.
- State 12 -> `rout` = 144 = 16'h0090; display digit0 = "0" (1000000), digit1 = "9" (0010000), digits 2-3 = "0".
